uart_tx_arbiter: RTL
====================

# uart_tx_arbiter

Shares the transmit side of one `uart_core` instance between `NUM_REQ` byte-stream requesters. Arbitration is round-robin and happens at packet granularity, so one requester's packet is never interleaved with another's. A length cap prevents a stuck requester from locking the line. A programmable idle gap is inserted after every packet. The block sits between the per-function message sources and the `uart_core` `tx_*` interface.

## Interface
- `NUM_REQ`, 4: number of requesters (2..8).
- `DATA_WIDTH`, 8: byte width; matches `uart_core`.
- `MAX_PKT_LEN`, 64: maximum bytes per grant before forced release (1..255).
- `GAP_CYCLES`, 16: minimum idle clocks after a packet, counted after its last byte is accepted (0..255).
- `clk` in 1: single clock for the whole block.
- `rst` in 1: reset, synchronous and active-high.
- `req_data` in `NUM_REQ*DATA_WIDTH`: requester *i* occupies bits `[i*DATA_WIDTH +: DATA_WIDTH]`.
- `req_valid` in `NUM_REQ`: per-requester byte valid.
- `req_last` in `NUM_REQ`: per-requester last-byte-of-packet flag, qualified by `req_valid`.
- `req_ready` out `NUM_REQ`: per-requester byte accepted strobe; one-hot or zero.
- `tx_data` out `DATA_WIDTH`: to `uart_core` `tx_data`.
- `tx_valid` out 1: to `uart_core` `tx_valid`.
- `tx_ready` in 1: from `uart_core` `tx_ready`.
- `tx_busy` in 1: from `uart_core` `tx_busy`.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or most recent grantee.
- `grant_active` out 1: high while in SEND.
- `pkt_abort` out 1: one-cycle pulse when a packet is cut at `MAX_PKT_LEN`.

## Operation
- FSM states are IDLE, SEND and GAP.
- **IDLE**
  - Find the first requester with `req_valid` set, searching from `last_grant+1` and wrapping modulo `NUM_REQ`.
  - If one is found, register `grant_id` to it, update `last_grant`, clear `byte_cnt`, and move to SEND.
  - If none is found, stay in IDLE.
- **SEND**
  - `tx_data` is driven from the granted requester's slice.
  - `tx_valid` equals `req_valid[grant_id]`.
  - `req_ready[grant_id]` equals `tx_ready`; all other `req_ready` bits are 0.
  - A byte is transferred when `tx_valid` and `tx_ready` are both high. Each transfer increments `byte_cnt` (8-bit, saturating is unnecessary because of the cap).
  - Transfer with `req_last` set: load `gap_cnt` with `GAP_CYCLES` and move to GAP.
  - Transfer without `req_last` where `byte_cnt+1 == MAX_PKT_LEN`: pulse `pkt_abort`, load `gap_cnt`, and move to GAP.
  - If the grantee drops `req_valid` mid-packet, the block holds the grant indefinitely. There is no timeout.
- **GAP**
  - All `req_ready` bits are 0 and `tx_valid` is 0.
  - `gap_cnt` decrements each cycle until it reaches 0.
  - Move to IDLE when `gap_cnt==0` and `tx_busy==0`, so the line is drained before the next grant.
- Requests arriving during SEND or GAP only wait. They are never dropped.
- Simultaneous last byte and cap: `req_last` has priority and `pkt_abort` is not pulsed.
- A reset mid-packet abandons the packet. The requester must restart it; the bench does not check partial-packet recovery.

## Timing
- Reset values:
  - state IDLE.
  - `last_grant` = `NUM_REQ-1`, so requester 0 wins first.
  - `grant_id` 0, `grant_active` 0, `pkt_abort` 0.
  - `tx_valid` 0, `tx_data` 0, `req_ready` 0.
  - `byte_cnt` 0, `gap_cnt` 0.
- Arbitration latency: a request first seen in IDLE at cycle N gives `grant_active` high and `tx_valid` visible at N+1.
- Datapath (`tx_data`, `tx_valid`, `req_ready`) is combinational from the registered `grant_id` and state. There is no added byte latency.
- `pkt_abort` is registered and asserted in the first GAP cycle.
- Minimum packet-to-packet spacing, measured from the last handshake to the next grant's first `tx_valid`, is `GAP_CYCLES+2` cycles when `tx_busy` is already low.
- With `GAP_CYCLES=0`, GAP lasts 1 cycle if `tx_busy` is low.

## Structure
- `uart_pkg` holds:
  - the `arb_state_t` enum (IDLE/SEND/GAP);
  - the `GRANT_W` helper function (`$clog2` with a minimum of 1).
- Sub-module `uart_rr_pick` is a combinational round-robin picker.
  - Inputs: `req` vector, `last` index.
  - Outputs: `found` flag and `idx`.
  - It is reused later for an RX dispatcher.
- Counters and FSM live in `uart_tx_arbiter`.

## Test plan
- **Single requester:** req 2 sends 3 bytes 0xA1,0xA2,0xA3 with last on 0xA3. Expect `grant_id`=2 one cycle after `req_valid`, the bytes on `tx_data` in order, then exactly `GAP_CYCLES` idle cycles before the next grant possibility.
- **Round-robin:** all 4 requesters hold 1-byte packets continuously after reset. Expect grant order 0,1,2,3,0 and no interleaving.
- **Length cap:** `MAX_PKT_LEN`=4, req 1 streams 6 bytes without last. Expect 4 bytes transferred, `pkt_abort` high for 1 cycle, and the next grant going to another waiting requester.
- **Backpressure:** hold `tx_ready` low for 10 cycles mid-packet. Expect `tx_data` stable, `req_ready` 0, and no `byte_cnt` change.
- **Gap and busy:** `GAP_CYCLES`=0, `tx_busy` held high 5 cycles after the last byte. Expect the FSM to stay in GAP until `tx_busy` falls, with IDLE on the following cycle.
- **Reset mid-SEND:** assert `rst` during byte 2. Expect all outputs at their reset values the next cycle and requester 0 winning first afterwards.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit arbiter and related blocks.
package uart_pkg;

  // Arbiter FSM: wait for a request, stream one packet, then hold off the line.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } arb_state_t;

  // Width of an index into n requesters; never narrower than one bit.
  function automatic int GRANT_W(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin picker: first set bit of req, searching upward
// from last+1 and wrapping. Shared by the TX arbiter and the RX dispatcher.
module uart_rr_pick
  import uart_pkg::*;
#(
  parameter int  N = 4,
  localparam int W = GRANT_W(N)
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] last,
  output logic         found,
  output logic [W-1:0] idx
);

  int cand;

  // Walk the N candidates in rotated order; the first requester seen wins.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    cand  = 0;
    for (int k = 1; k <= N; k++) begin
      cand = (int'(last) + k) % N;
      if (!found && req[cand]) begin
        found = 1'b1;
        idx   = W'(cand);
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Shares the transmit side of one uart_core between NUM_REQ byte-stream
// requesters. Round-robin at packet granularity, a per-grant length cap and
// a programmable idle gap after every packet.
//
// Handshake: every byte channel (req_* and tx_*) is valid/ready. A byte moves
// on a rising clk edge where valid and ready are both high; a source that
// raises valid keeps data and last stable until that edge. Here tx_valid
// mirrors the grantee's req_valid and the grantee's req_ready mirrors
// tx_ready, so a requester handshake and a uart_core handshake are the same
// event.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int  NUM_REQ     = 4,
  parameter int  DATA_WIDTH  = 8,
  parameter int  MAX_PKT_LEN = 64,
  parameter int  GAP_CYCLES  = 16,
  localparam int GW          = GRANT_W(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ-1:0]            req_last,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic [DATA_WIDTH-1:0]         tx_data,
  output logic                          tx_valid,
  input  logic                          tx_ready,
  input  logic                          tx_busy,
  output logic [GW-1:0]                 grant_id,
  output logic                          grant_active,
  output logic                          pkt_abort,
  output logic [1:0]                    state_dbg
);

  arb_state_t    state;
  arb_state_t    state_nxt;
  logic [GW-1:0] last_grant;
  logic [7:0]    byte_cnt;
  logic [7:0]    gap_cnt;

  logic          pick_found;
  logic [GW-1:0] pick_idx;
  logic          xfer;
  logic          last_hit;
  logic          cap_hit;
  logic          gap_done;

  uart_rr_pick #(
    .N (NUM_REQ)
  ) u_pick (
    .req   (req_valid),
    .last  (last_grant),
    .found (pick_found),
    .idx   (pick_idx)
  );

  // Byte-level conditions of the current grant.
  assign last_hit = req_last[grant_id];
  assign cap_hit  = ((byte_cnt + 8'd1) == 8'(MAX_PKT_LEN));

  // gap_cnt counts the GAP cycles still to run including the current one, so
  // leaving at 1 gives GAP_CYCLES idle clocks; a zero load still costs one
  // GAP cycle. While tx_busy holds, the counter rests at 0.
  assign gap_done = (gap_cnt <= 8'd1) && !tx_busy;

  assign grant_active = (state == ST_SEND);
  assign state_dbg    = state;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and the combinational datapath from the registered grant.
  always_comb begin
    state_nxt = state;
    tx_data   = '0;
    tx_valid  = 1'b0;
    req_ready = '0;
    xfer      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (pick_found) begin
          state_nxt = ST_SEND;
        end
      end
      ST_SEND: begin
        tx_data             = req_data[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH];
        tx_valid            = req_valid[grant_id];
        req_ready[grant_id] = tx_ready;
        xfer                = req_valid[grant_id] && tx_ready;
        // A stalled grantee keeps the grant; there is deliberately no timeout.
        if (xfer && (last_hit || cap_hit)) begin
          state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        if (gap_done) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Grant bookkeeping, byte and gap counters, and the abort pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant <= GW'(NUM_REQ - 1);
      grant_id   <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
      pkt_abort  <= 1'b0;
    end else begin
      pkt_abort <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (pick_found) begin
            grant_id   <= pick_idx;
            last_grant <= pick_idx;
            byte_cnt   <= '0;
          end
        end
        ST_SEND: begin
          if (xfer) begin
            byte_cnt <= byte_cnt + 8'd1;
            if (last_hit || cap_hit) begin
              gap_cnt <= 8'(GAP_CYCLES);
            end
            // A real last byte landing on the cap is a clean end, not a cut.
            if (!last_hit && cap_hit) begin
              pkt_abort <= 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_cnt != 8'd0) begin
            gap_cnt <= gap_cnt - 8'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

endmodule
